bscan_tap_ctrl: RTL and testbench
=================================

Name: bscan_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller that sequences a chain of boundary-scan cells (capture/shift/update/mode cells) on a single system clock.
- Contains the 16-state TAP FSM, an instruction register, and a bypass register. A compiled-in option adds an IDCODE register.
- Drives the control pins shared by every cell in the chain, and muxes the chain's serial output onto tdo.

Parameters:
- IR_WIDTH, 4, instruction register width (min 2).
- IDCODE_VAL, 32'h0000_0001, device ID value; bit 0 must be 1; only used with the option.

Ports:
- clk  in  1  scan clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- tms  in  1  test mode select, sampled on clk rising edge.
- tdi  in  1  serial data in; also drives bc_si.
- tdo  out  1  serial data out.
- tdo_en  out  1  high only in SHIFT_DR or SHIFT_IR.
- bc_si  out  1  chain serial input (= tdi).
- bc_so  in  1  serial output of the last cell in the chain.
- bc_capture_en  out  1  active-low capture/shift enable to the cells.
- bc_shift_dr  out  1  high selects shift, low selects capture.
- bc_update_en  out  1  update strobe to the cells.
- bc_mode  out  1  1 = cells drive the update-stage value; 0 = transparent.
- state_o  out  4  current TAP state encoding, for debug.

Behaviour:
- FSM states and encoding:
  - TLR 0, RTI 1, SEL_DR 2, CAP_DR 3, SH_DR 4, EX1_DR 5, PA_DR 6, EX2_DR 7, UPD_DR 8,
  - SEL_IR 9, CAP_IR 10, SH_IR 11, EX1_IR 12, PA_IR 13, EX2_IR 14, UPD_IR 15.
- FSM transitions follow the standard 1149.1 TMS graph, one transition per clk edge. Key transitions:
  - TLR: tms=0 -> RTI.
  - SEL_IR: tms=1 -> TLR.
  - UPD_x: tms=1 -> SEL_DR; tms=0 -> RTI.
  - Five consecutive tms=1 reach TLR from any state.
- rst=1, including mid-shift:
  - state=TLR; ir_cur=BYPASS (IDCODE with the option); ir_shift=0; bypass=0.
  - All bc_* controls and tdo_en deasserted on the next edge; partial shift contents are discarded.
- Entering TLR through TMS has the same effect on ir_cur as rst.
- Opcodes (IR_WIDTH=4; the all-ones width rule holds for any width):
  - EXTEST=0000, SAMPLE=0001, IDCODE=0010, BYPASS=all ones.
  - Any other code decodes as BYPASS.
- IR path:
  - CAP_IR loads ir_shift = {0..0,01}.
  - SH_IR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}; tdo = ir_shift[0].
  - UPD_IR: ir_cur <= ir_shift at the edge leaving UPD_IR.
  - ir_cur is unchanged in every other state.
- DR path, by decoded ir_cur:
  - EXTEST/SAMPLE: chain selected; tdo = bc_so.
  - BYPASS: 1-bit reg, CAP_DR loads 0, SH_DR loads tdi; tdo = bypass.
  - IDCODE: see Optional Feature.
- Cell controls are Moore outputs decoded from the registered state and ir_cur; no extra latency:
  - bc_capture_en = 0 in CAP_DR and SH_DR when the chain is selected; 1 otherwise.
  - bc_shift_dr = 1 in SH_DR only.
  - bc_update_en = 1 in UPD_DR when the chain is selected (one cycle per pass).
  - bc_mode = 1 iff ir_cur=EXTEST; it changes the cycle after UPD_IR.
- tdo = 0 whenever tdo_en = 0.
- PA_DR/PA_IR hold all shift registers; EX1/EX2 states do not shift.
- With BYPASS selected, the chain receives no capture or update strobes.

Optional Feature:
- Macro BSCAN_TAP_IDCODE_EN.
- Defined:
  - 32-bit id reg; CAP_DR with IDCODE selected loads IDCODE_VAL.
  - SH_DR shifts LSB first (tdo = id[0], tdi in at bit 31).
  - rst and TLR load ir_cur=IDCODE.
- Undefined:
  - No id reg is synthesised.
  - Opcode IDCODE decodes as BYPASS.
  - Reset instruction is BYPASS.

Test Plan:
- Reset: rst=1 for 2 clks from SH_DR -> state_o=0, bc_capture_en=1, bc_update_en=0, bc_mode=0, tdo_en=0.
- TMS walk: tms 0,1,0,0 from TLR -> states RTI, SEL_DR, CAP_DR, SH_DR; five tms=1 from SH_IR -> TLR.
- IR load EXTEST: shift 0000 through SH_IR -> tdo emits 1,0,0,0 (the capture pattern); after UPD_IR, bc_mode=1 next cycle.
- SAMPLE DR pass:
  - CAP_DR -> bc_capture_en=0, bc_shift_dr=0.
  - 8 SH_DR cycles -> bc_shift_dr=1, tdo mirrors bc_so.
  - UPD_DR -> bc_update_en=1 for exactly 1 cycle; bc_mode=0.
- BYPASS/unknown: IR=1010 with tdi stream 1,1,0 in SH_DR -> tdo 0,1,1 (1-cycle delay); bc_capture_en stays 1, no update strobe.
- Option on: after rst, DR scan of 32 bits -> tdo returns IDCODE_VAL LSB first, first bit 1. Option off: same scan -> a single 0 followed by the tdi stream delayed by one cycle.

Source files
------------

// File: rtl/bscan_tap_ctrl.sv
// IEEE 1149.1-style TAP controller driving a shared boundary-scan cell chain.
// Define BSCAN_TAP_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the reset instruction.
module bscan_tap_ctrl #(
  parameter int unsigned IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_en,
  output logic       bc_si,
  input  logic       bc_so,
  output logic       bc_capture_en,
  output logic       bc_shift_dr,
  output logic       bc_update_en,
  output logic       bc_mode,
  output logic [3:0] state_o
);

  localparam int unsigned STATE_WIDTH = 4;
  localparam logic [IR_WIDTH-1:0] OP_EXTEST  = '0;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef BSCAN_TAP_IDCODE_EN
  localparam int unsigned ID_WIDTH = 32;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] RST_INSTR = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RST_INSTR = OP_BYPASS;
`endif

  // Elaboration-time parameter sanity check
  if (IR_WIDTH < 2 || IDCODE_VAL[0] != 1'b1) begin : g_param_err
    $error("bscan_tap_ctrl: IR_WIDTH must be >= 2 and IDCODE_VAL[0] must be 1");
  end

  typedef enum logic [STATE_WIDTH-1:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e          state;
  tap_state_e          next_state;
  logic [IR_WIDTH-1:0] ir_cur;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass;
  logic                sel_chain;
  logic                sel_bypass;
`ifdef BSCAN_TAP_IDCODE_EN
  logic                sel_id;
  logic [ID_WIDTH-1:0] id_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= TLR;
    else     state <= next_state;
  end

  // Standard 1149.1 TMS graph
  always_comb begin
    next_state = state;
    case (state)
      TLR:    next_state = tms ? TLR    : RTI;
      RTI:    next_state = tms ? SEL_DR : RTI;
      SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms ? UPD_DR : PA_DR;
      PA_DR:  next_state = tms ? EX2_DR : PA_DR;
      EX2_DR: next_state = tms ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR: next_state = tms ? TLR    : CAP_IR;
      CAP_IR: next_state = tms ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms ? UPD_IR : PA_IR;
      PA_IR:  next_state = tms ? EX2_IR : PA_IR;
      EX2_IR: next_state = tms ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // Instruction decode; unlisted opcodes fall through to BYPASS
  always_comb begin
    sel_chain  = (ir_cur == OP_EXTEST) || (ir_cur == OP_SAMPLE);
`ifdef BSCAN_TAP_IDCODE_EN
    sel_id     = (ir_cur == OP_IDCODE);
    sel_bypass = !sel_chain && !sel_id;
`else
    sel_bypass = !sel_chain;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_cur   <= RST_INSTR;
      ir_shift <= '0;
      bypass   <= 1'b0;
`ifdef BSCAN_TAP_IDCODE_EN
      id_reg   <= IDCODE_VAL;
`endif
    end else begin
      if (next_state == TLR)  ir_cur <= RST_INSTR;
      else if (state == UPD_IR) ir_cur <= ir_shift;

      case (state)
        CAP_IR:  ir_shift <= IR_CAPTURE;
        SH_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
        default: ;
      endcase

      if (sel_bypass) begin
        if (state == CAP_DR)     bypass <= 1'b0;
        else if (state == SH_DR) bypass <= tdi;
      end
`ifdef BSCAN_TAP_IDCODE_EN
      if (sel_id) begin
        if (state == CAP_DR)     id_reg <= IDCODE_VAL;
        else if (state == SH_DR) id_reg <= {tdi, id_reg[ID_WIDTH-1:1]};
      end
`endif
    end
  end

  // Moore decode of cell controls and serial output from registered state
  always_comb begin
    tdo_en        = (state == SH_DR) || (state == SH_IR);
    tdo           = 1'b0;
    bc_si         = tdi;
    bc_capture_en = !(sel_chain && ((state == CAP_DR) || (state == SH_DR)));
    bc_shift_dr   = (state == SH_DR);
    bc_update_en  = sel_chain && (state == UPD_DR);
    bc_mode       = (ir_cur == OP_EXTEST);
    state_o       = STATE_WIDTH'(state);
    if (state == SH_IR) begin
      tdo = ir_shift[0];
    end else if (state == SH_DR) begin
      if (sel_chain) tdo = bc_so;
`ifdef BSCAN_TAP_IDCODE_EN
      else if (sel_id) tdo = id_reg[0];
`endif
      else tdo = bypass;
    end
  end

endmodule

// File: tb/tb_bscan_tap_ctrl.sv
// Directed self-checking bench for bscan_tap_ctrl; honours BSCAN_TAP_IDCODE_EN when defined.
module tb_bscan_tap_ctrl;

  localparam logic [31:0] TB_ID = 32'h1234_5679;

  logic       clk = 1'b0;
  logic       rst;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic       bc_si;
  logic       bc_so;
  logic       bc_capture_en;
  logic       bc_shift_dr;
  logic       bc_update_en;
  logic       bc_mode;
  logic [3:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  bscan_tap_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(TB_ID)) dut (
    .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bc_si(bc_si), .bc_so(bc_so), .bc_capture_en(bc_capture_en),
    .bc_shift_dr(bc_shift_dr), .bc_update_en(bc_update_en), .bc_mode(bc_mode),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_cap_en"}, 32'(bc_capture_en), 32'd1);
    chk({tag, "_shift"}, 32'(bc_shift_dr), 32'd0);
    chk({tag, "_upd"}, 32'(bc_update_en), 32'd0);
    chk({tag, "_mode"}, 32'(bc_mode), 32'd0);
    chk({tag, "_tdo_en"}, 32'(tdo_en), 32'd0);
  endtask

  // Load an IR value LSB first from RTI/TLR-adjacent SEL_DR entry; ends in RTI
  task automatic load_ir(input logic [3:0] op, input string tag);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, op[i]);
    step(1'b1, 1'b0);
    chk({tag, "_upd_ir"}, 32'(state_o), 32'd15);
    step(1'b0, 1'b0);
  endtask

  logic [31:0] pat;
  logic [7:0]  so_pat;
  logic        exp_bit;

  initial begin
    rst = 1'b1; tms = 1'b0; tdi = 1'b0; bc_so = 1'b0;
    pat = 32'hA5C3_961E;
    so_pat = 8'b1011_0010;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    chk_reset("por");

    // TMS walk to SH_DR, then reset mid-shift
    step(1'b0, 1'b0); chk("walk_rti", 32'(state_o), 32'd1);
    step(1'b1, 1'b0); chk("walk_seldr", 32'(state_o), 32'd2);
    step(1'b0, 1'b0); chk("walk_capdr", 32'(state_o), 32'd3);
    step(1'b0, 1'b0); chk("walk_shdr", 32'(state_o), 32'd4);
    chk("shdr_tdo_en", 32'(tdo_en), 32'd1);
    chk("shdr_shift", 32'(bc_shift_dr), 32'd1);
    tdi = 1'b1; #1;
    chk("bc_si", 32'(bc_si), 32'd1);
    rst = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rst = 1'b0;
    chk_reset("rst_mid");

    // EXTEST load: capture pattern shifts out 1,0,0,0
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk("selir", 32'(state_o), 32'd9);
    step(1'b0, 1'b0); chk("capir", 32'(state_o), 32'd10);
    step(1'b0, 1'b0); chk("shir", 32'(state_o), 32'd11);
    chk("shir_tdo_en", 32'(tdo_en), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ir_tdo%0d", i), 32'(tdo), (i == 0) ? 32'd1 : 32'd0);
      step(i == 3, 1'b0);
    end
    chk("ex1ir", 32'(state_o), 32'd12);
    chk("ex1ir_tdo", 32'(tdo), 32'd0);
    step(1'b1, 1'b0); chk("updir", 32'(state_o), 32'd15);
    chk("mode_in_updir", 32'(bc_mode), 32'd0);
    step(1'b0, 1'b0); chk("mode_extest", 32'(bc_mode), 32'd1);

    // TLR via TMS restores the reset instruction
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk("tms_tlr", 32'(state_o), 32'd0);
    chk("tms_tlr_mode", 32'(bc_mode), 32'd0);
    step(1'b0, 1'b0);

    // SAMPLE DR pass through the chain
    load_ir(4'b0001, "sample");
    chk("sample_mode", 32'(bc_mode), 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); chk("s_capdr", 32'(state_o), 32'd3);
    chk("s_cap_en", 32'(bc_capture_en), 32'd0);
    chk("s_cap_shift", 32'(bc_shift_dr), 32'd0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bc_so = so_pat[i]; #1;
      chk($sformatf("s_tdo%0d", i), 32'(tdo), 32'(so_pat[i]));
      chk($sformatf("s_shift%0d", i), 32'(bc_shift_dr), 32'd1);
      chk($sformatf("s_sh_cap%0d", i), 32'(bc_capture_en), 32'd0);
      step(i == 7, 1'b0);
    end
    chk("s_ex1_upd", 32'(bc_update_en), 32'd0);
    step(1'b1, 1'b0); chk("s_upd", 32'(bc_update_en), 32'd1);
    chk("s_upd_mode", 32'(bc_mode), 32'd0);
    step(1'b0, 1'b0); chk("s_upd_off", 32'(bc_update_en), 32'd0);
    bc_so = 1'b0;

    // Unknown opcode 1010 behaves as BYPASS
    load_ir(4'b1010, "unk");
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); chk("b_cap_en", 32'(bc_capture_en), 32'd1);
    step(1'b0, 1'b0);
    chk("b_tdo0", 32'(tdo), 32'd0);
    chk("b_sh_cap", 32'(bc_capture_en), 32'd1);
    step(1'b0, 1'b1); chk("b_tdo1", 32'(tdo), 32'd1);
    step(1'b0, 1'b1); chk("b_tdo2", 32'(tdo), 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk("b_upd", 32'(bc_update_en), 32'd0);
    step(1'b0, 1'b0);

    // Five TMS=1 from SH_IR reach TLR
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0); chk("five_start", 32'(state_o), 32'd11);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("five_tlr", 32'(state_o), 32'd0);

    // 32-bit DR scan after reset
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
`ifdef BSCAN_TAP_IDCODE_EN
      exp_bit = TB_ID[i];
`else
      exp_bit = (i == 0) ? 1'b0 : pat[i-1];
`endif
      chk($sformatf("scan%0d", i), 32'(tdo), 32'(exp_bit));
      step(i == 31, pat[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); chk("scan_end", 32'(state_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
